// File: rtl/rv_prog_encoder_if.sv
// Instruction-side handshake and memory-write bus of the RV32I program encoder.
interface rv_prog_encoder_if #(
   parameter int ADDR_W = 6
);
   logic                in_valid;
   logic                in_ready;
   logic [3:0]          in_op;
   logic [4:0]          in_rd;
   logic [4:0]          in_rs1;
   logic [4:0]          in_rs2;
   logic signed [12:0]  in_imm;
   logic                finish;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [31:0]         mem_wdata;
   logic                mem_ack;
   logic                done;
   logic                err;
   logic [7:0]          err_cnt;

   // Instruction source / memory side
   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, finish, mem_ack,
      input  in_ready, mem_we, mem_addr, mem_wdata, done, err, err_cnt
   );

   // Encoder side
   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, finish, mem_ack,
      output in_ready, mem_we, mem_addr, mem_wdata, done, err, err_cnt
   );
endinterface

// File: rtl/rv_prog_encoder.sv
// Packs symbolic RV32I instructions into machine words, writes them to
// sequential instruction-memory addresses and closes the program with a halt.
module rv_prog_encoder #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   rv_prog_encoder_if.slave  bus
);

   typedef enum logic [1:0] {S_RUN, S_FULL, S_HALT, S_DONE} state_t;

   localparam logic [31:0]     HALT_WORD = 32'h0000_0063;   // BEQ x0,x0,0
   localparam logic [ADDR_W:0] PRE_FULL  = (ADDR_W+1)'(DEPTH-2);

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;
   localparam logic [6:0] OPC_L = 7'b0000011;
   localparam logic [6:0] OPC_S = 7'b0100011;
   localparam logic [6:0] OPC_B = 7'b1100011;

   // Pure combinational field packing; op 14/15 yields 0 (never written).
   function automatic logic [31:0] enc_word(input logic [3:0] op,
                                            input logic [4:0] rd,
                                            input logic [4:0] rs1,
                                            input logic [4:0] rs2,
                                            input logic signed [12:0] imm);
      logic [31:0] w;
      w = '0;
      case (op)
         4'd0:  w = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
         4'd1:  w = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
         4'd2:  w = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
         4'd3:  w = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
         4'd4:  w = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_R};
         4'd5:  w = {7'b0000000, rs2, rs1, 3'b100, rd, OPC_R};
         4'd6:  w = {imm[11:0], rs1, 3'b000, rd, OPC_I};
         4'd7:  w = {imm[11:0], rs1, 3'b111, rd, OPC_I};
         4'd8:  w = {imm[11:0], rs1, 3'b110, rd, OPC_I};
         4'd9:  w = {imm[11:0], rs1, 3'b000, rd, OPC_L};
         4'd10: w = {imm[11:0], rs1, 3'b010, rd, OPC_L};
         4'd11: w = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], OPC_S};
         4'd12: w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_S};
         4'd13: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_B};
         default: w = '0;
      endcase
      return w;
   endfunction

   // Unknown opcode, 12-bit immediate overflow on I/S types, odd branch offset.
   function automatic logic is_illegal(input logic [3:0] op,
                                       input logic signed [12:0] imm);
      logic bad;
      bad = 1'b0;
      if (op >= 4'd14)                      bad = 1'b1;
      else if (op >= 4'd6 && op <= 4'd12)   bad = (imm[12] != imm[11]);
      else if (op == 4'd13)                 bad = imm[0];
      return bad;
   endfunction

   state_t            r_state;
   state_t            w_next;
   logic              r_pend;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [ADDR_W:0]   r_cnt;
   logic              r_fin;
   logic              r_err;
   logic [7:0]        r_err_cnt;

   logic              w_in_ready;
   logic              w_hs;
   logic              w_ack;
   logic              w_illegal;
   logic [31:0]       w_word;
   logic              w_go_halt;

   assign w_ack      = bus.mem_ack & r_pend;
   assign w_in_ready = (~r_pend | bus.mem_ack) & (r_state == S_RUN) & ~r_fin;
   assign w_hs       = bus.in_valid & w_in_ready;
   assign w_illegal  = is_illegal(bus.in_op, bus.in_imm);
   assign w_word     = enc_word(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_RUN;
      else        r_state <= w_next;
   end

   // Next state: the halt word is issued once finish is latched and the last word drains
   always_comb begin
      w_next    = r_state;
      w_go_halt = 1'b0;
      case (r_state)
         S_RUN: begin
            if (r_fin && (!r_pend || w_ack)) begin
               w_next    = S_HALT;
               w_go_halt = 1'b1;
            end else if (w_hs && !w_illegal && r_cnt == PRE_FULL) begin
               w_next = S_FULL;
            end
         end
         S_FULL: begin
            if (r_fin && (!r_pend || w_ack)) begin
               w_next    = S_HALT;
               w_go_halt = 1'b1;
            end
         end
         S_HALT:  if (w_ack) w_next = S_DONE;
         S_DONE:  w_next = S_DONE;
         default: w_next = S_RUN;
      endcase
   end

   // Pending write word, address counter, finish latch and error reporting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_fin     <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= 1'b0;
         if (w_ack) begin
            r_pend <= 1'b0;
            r_addr <= r_addr + ADDR_W'(1);
         end
         if (w_hs) begin
            if (w_illegal) begin
               r_err <= 1'b1;
               if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
               r_pend  <= 1'b1;
               r_wdata <= w_word;
               r_cnt   <= r_cnt + (ADDR_W+1)'(1);
            end
         end
         if (w_go_halt) begin
            r_pend  <= 1'b1;
            r_wdata <= HALT_WORD;
         end
         if ((r_state == S_RUN || r_state == S_FULL) && bus.finish) r_fin <= 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.mem_we    = r_pend;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.done      = (r_state == S_DONE);
   assign bus.err       = r_err;
   assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rv_prog_encoder.sv
// Directed bench for rv_prog_encoder: a 64-word instance and a 4-word instance.
module tb_rv_prog_encoder;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   rv_prog_encoder_if #(.ADDR_W(6)) b64 ();
   rv_prog_encoder_if #(.ADDR_W(6)) b4 ();

   rv_prog_encoder #(.ADDR_W(6), .DEPTH(64)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b64.slave));
   rv_prog_encoder #(.ADDR_W(6), .DEPTH(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm);
      b64.in_op    = op;
      b64.in_rd    = rd;
      b64.in_rs1   = rs1;
      b64.in_rs2   = rs2;
      b64.in_imm   = imm;
      b64.in_valid = 1'b1;
   endtask

   task automatic put4(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [12:0] imm);
      b4.in_op    = op;
      b4.in_rd    = rd;
      b4.in_rs1   = rs1;
      b4.in_rs2   = rs2;
      b4.in_imm   = imm;
      b4.in_valid = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  v_op  [4];
      logic [4:0]  v_rd  [4];
      logic [4:0]  v_rs1 [4];
      logic [4:0]  v_rs2 [4];
      logic [12:0] v_imm [4];
      logic [31:0] v_exp [4];
      int n;

      // SUB x5,x6,x7 ; ADDI x1,x0,-1 ; SW x2,8(x1) ; BEQ x1,x2,+16
      v_op[0] = 4'd1;  v_rd[0] = 5'd5; v_rs1[0] = 5'd6; v_rs2[0] = 5'd7; v_imm[0] = 13'd0;     v_exp[0] = 32'h407302B3;
      v_op[1] = 4'd6;  v_rd[1] = 5'd1; v_rs1[1] = 5'd0; v_rs2[1] = 5'd0; v_imm[1] = 13'h1FFF;  v_exp[1] = 32'hFFF00093;
      v_op[2] = 4'd12; v_rd[2] = 5'd0; v_rs1[2] = 5'd1; v_rs2[2] = 5'd2; v_imm[2] = 13'd8;     v_exp[2] = 32'h0020A423;
      v_op[3] = 4'd13; v_rd[3] = 5'd0; v_rs1[3] = 5'd1; v_rs2[3] = 5'd2; v_imm[3] = 13'd16;    v_exp[3] = 32'h00208863;

      rst_n = 1'b0;
      b64.in_valid = 1'b0; b64.in_op = '0; b64.in_rd = '0; b64.in_rs1 = '0; b64.in_rs2 = '0;
      b64.in_imm = '0; b64.finish = 1'b0; b64.mem_ack = 1'b0;
      b4.in_valid = 1'b0; b4.in_op = '0; b4.in_rd = '0; b4.in_rs1 = '0; b4.in_rs2 = '0;
      b4.in_imm = '0; b4.finish = 1'b0; b4.mem_ack = 1'b0;
      cyc();
      cyc();

      // Reset values
      chk("rst_in_ready", b64.in_ready, 1);
      chk("rst_mem_we",   b64.mem_we, 0);
      chk("rst_addr",     b64.mem_addr, 0);
      chk("rst_wdata",    b64.mem_wdata, 0);
      chk("rst_done",     b64.done, 0);
      chk("rst_err",      b64.err, 0);
      chk("rst_err_cnt",  b64.err_cnt, 0);
      rst_n = 1'b1;
      cyc();

      // Single ADD x3,x1,x2 with ack tied high
      b64.mem_ack = 1'b1;
      put(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
      chk("add_ready", b64.in_ready, 1);
      cyc();
      b64.in_valid = 1'b0;
      chk("add_we",    b64.mem_we, 1);
      chk("add_addr",  b64.mem_addr, 0);
      chk("add_wdata", b64.mem_wdata, 32'h002081B3);
      cyc();
      chk("add_drain_we",   b64.mem_we, 0);
      chk("add_drain_addr", b64.mem_addr, 1);

      // Asynchronous reset clears the address immediately
      rst_n = 1'b0;
      #1;
      chk("async_rst_addr", b64.mem_addr, 0);
      #1;
      rst_n = 1'b1;
      cyc();

      // Back-to-back stream, one word per cycle
      for (int i = 0; i < 4; i++) begin
         put(v_op[i], v_rd[i], v_rs1[i], v_rs2[i], v_imm[i]);
         chk("b2b_ready", b64.in_ready, 1);
         cyc();
         chk("b2b_we",    b64.mem_we, 1);
         chk("b2b_addr",  b64.mem_addr, i);
         chk("b2b_wdata", b64.mem_wdata, v_exp[i]);
      end
      b64.in_valid = 1'b0;
      cyc();
      chk("b2b_end_we",   b64.mem_we, 0);
      chk("b2b_end_addr", b64.mem_addr, 4);

      // Memory stall: outputs hold, in_ready low until the ack cycle
      b64.mem_ack = 1'b0;
      put(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
      cyc();
      chk("stall_we0",    b64.mem_we, 1);
      chk("stall_addr0",  b64.mem_addr, 4);
      chk("stall_wdata0", b64.mem_wdata, 32'h002081B3);
      put(4'd3, 5'd1, 5'd2, 5'd3, 13'd0);       // OR x1,x2,x3 waiting
      for (int k = 0; k < 3; k++) begin
         chk("stall_ready", b64.in_ready, 0);
         cyc();
         chk("stall_we",    b64.mem_we, 1);
         chk("stall_addr",  b64.mem_addr, 4);
         chk("stall_wdata", b64.mem_wdata, 32'h002081B3);
      end
      b64.mem_ack = 1'b1;
      #1;
      chk("ack_ready", b64.in_ready, 1);
      cyc();
      b64.in_valid = 1'b0;
      chk("or_we",    b64.mem_we, 1);
      chk("or_addr",  b64.mem_addr, 5);
      chk("or_wdata", b64.mem_wdata, 32'h003160B3);
      cyc();
      chk("or_drain_we", b64.mem_we, 0);
      chk("or_drain_addr", b64.mem_addr, 6);

      // Illegal instructions: bad op, ADDI +2048, odd BEQ offset
      put(4'd15, 5'd1, 5'd1, 5'd1, 13'd0);
      cyc();
      chk("ill_op_err", b64.err, 1);
      chk("ill_op_cnt", b64.err_cnt, 1);
      chk("ill_op_we",  b64.mem_we, 0);
      put(4'd6, 5'd1, 5'd0, 5'd0, 13'h0800);
      cyc();
      chk("ill_imm_err", b64.err, 1);
      chk("ill_imm_cnt", b64.err_cnt, 2);
      chk("ill_imm_we",  b64.mem_we, 0);
      put(4'd13, 5'd0, 5'd1, 5'd2, 13'd3);
      cyc();
      chk("ill_beq_err", b64.err, 1);
      chk("ill_beq_cnt", b64.err_cnt, 3);
      chk("ill_beq_we",  b64.mem_we, 0);
      b64.in_valid = 1'b0;
      cyc();
      chk("ill_err_low", b64.err, 0);
      chk("ill_cnt_hold", b64.err_cnt, 3);
      chk("ill_addr",    b64.mem_addr, 6);

      // err_cnt saturates at 255
      put(4'd14, 5'd0, 5'd0, 5'd0, 13'd0);
      for (int k = 0; k < 260; k++) cyc();
      b64.in_valid = 1'b0;
      cyc();
      chk("sat_cnt",  b64.err_cnt, 255);
      chk("sat_addr", b64.mem_addr, 6);
      chk("sat_we",   b64.mem_we, 0);

      // DEPTH=4: three words fill, then finish writes the halt at address 3
      b4.mem_ack = 1'b1;
      put4(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
      cyc();
      chk("d4_addr0",  b4.mem_addr, 0);
      chk("d4_wdata0", b4.mem_wdata, 32'h002081B3);
      put4(4'd1, 5'd5, 5'd6, 5'd7, 13'd0);
      cyc();
      chk("d4_addr1",  b4.mem_addr, 1);
      chk("d4_wdata1", b4.mem_wdata, 32'h407302B3);
      put4(4'd6, 5'd1, 5'd0, 5'd0, 13'h1FFF);
      cyc();
      b4.in_valid = 1'b0;
      chk("d4_addr2",  b4.mem_addr, 2);
      chk("d4_wdata2", b4.mem_wdata, 32'hFFF00093);
      chk("d4_full_ready", b4.in_ready, 0);
      b4.finish = 1'b1;
      cyc();
      b4.finish = 1'b0;
      n = 0;
      while (b4.mem_we !== 1'b1 && n < 8) begin
         cyc();
         n++;
      end
      chk("d4_halt_we",    b4.mem_we, 1);
      chk("d4_halt_addr",  b4.mem_addr, 3);
      chk("d4_halt_wdata", b4.mem_wdata, 32'h00000063);
      chk("d4_halt_done",  b4.done, 0);
      cyc();
      chk("d4_done",       b4.done, 1);
      chk("d4_done_we",    b4.mem_we, 0);
      chk("d4_done_ready", b4.in_ready, 0);

      // finish with the last instruction, then reset during HALT
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      cyc();
      b64.mem_ack = 1'b0;
      put(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
      b64.finish = 1'b1;
      chk("fin_ready", b64.in_ready, 1);
      cyc();
      b64.in_valid = 1'b0;
      b64.finish   = 1'b0;
      chk("fin_word_we",    b64.mem_we, 1);
      chk("fin_word_addr",  b64.mem_addr, 0);
      chk("fin_word_wdata", b64.mem_wdata, 32'h002081B3);
      chk("fin_ready_low",  b64.in_ready, 0);
      b64.mem_ack = 1'b1;
      cyc();
      b64.mem_ack = 1'b0;
      n = 0;
      while (!(b64.mem_we === 1'b1 && b64.mem_wdata === 32'h00000063) && n < 8) begin
         cyc();
         n++;
      end
      chk("fin_halt_we",    b64.mem_we, 1);
      chk("fin_halt_wdata", b64.mem_wdata, 32'h00000063);
      chk("fin_halt_addr",  b64.mem_addr, 1);
      cyc();
      chk("fin_halt_hold",  b64.mem_we, 1);
      chk("fin_halt_done",  b64.done, 0);
      rst_n = 1'b0;
      #2;
      chk("hrst_in_ready", b64.in_ready, 1);
      chk("hrst_mem_we",   b64.mem_we, 0);
      chk("hrst_addr",     b64.mem_addr, 0);
      chk("hrst_wdata",    b64.mem_wdata, 0);
      chk("hrst_done",     b64.done, 0);
      chk("hrst_err",      b64.err, 0);
      chk("hrst_err_cnt",  b64.err_cnt, 0);
      chk("hrst_d4_done",  b4.done, 0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_ready", b64.in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
